// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts RUN cycles, stalls, flushes and retires, with a
// request/acknowledge snapshot port. Define PERF_RETIRE_EN to build the retire counter.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             snap_req_i,
  input  logic             snap_ack_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic             running_o,
  output logic             halted_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] cycle_next;
  logic             limit_hit;
  logic             capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  // Compare in a 64-bit domain so a limit wider than the counter can never alias.
  assign cycle_next = sat_inc(cycle_cnt, 1'b1);
  assign limit_hit  = (CYCLE_LIMIT != 0) && (64'(cycle_next) == 64'(CYCLE_LIMIT));
  assign capture    = snap_req_i && (!snap_valid_o || snap_ack_i);

  always_comb begin
    state_next = state;
    if (clr_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_next = RUN;
        RUN:     if (limit_hit) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status flags are flopped from the next-state decode so they carry no input paths.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
      halted_o  <= 1'b0;
    end else begin
      state     <= state_next;
      running_o <= (state_next == RUN);
      halted_o  <= (state_next == HALT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_next;
      stall_cnt <= sat_inc(stall_cnt, stall_i && !branch_i);
      flush_cnt <= sat_inc(flush_cnt, flush_i);
    end
  end

  // Snapshot captures pre-update counter values and is untouched by clr_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_valid_o <= 1'b0;
      snap_cycle_o <= '0;
      snap_stall_o <= '0;
      snap_flush_o <= '0;
    end else if (capture) begin
      snap_valid_o <= 1'b1;
      snap_cycle_o <= cycle_cnt;
      snap_stall_o <= stall_cnt;
      snap_flush_o <= flush_cnt;
    end else if (snap_ack_i) begin
      snap_valid_o <= 1'b0;
    end
  end

`ifdef PERF_RETIRE_EN
  logic [CNT_W-1:0] retire_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retire_cnt <= '0;
    end else if (clr_i) begin
      retire_cnt <= '0;
    end else if (state == RUN) begin
      retire_cnt <= sat_inc(retire_cnt, retire_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_retire_o <= '0;
    end else if (capture) begin
      snap_retire_o <= retire_cnt;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
  assign snap_retire_o = '0;
`endif

endmodule
